// File: rtl/commit_unit.sv
// commit_unit
//
// In-order retirement stage behind the reorder buffer's commit port. Each
// accepted entry produces:
//   - a registered register-file writeback (suppressed for rd = x0);
//   - a branch-predictor training update for conditional branches;
//   - on a mispredict, a one-cycle fetch redirect and a multi-cycle
//     clear_branch_out flush of the speculative machinery.
// It also counts retired instructions and mispredicts.
//
// Ports
//   clk_in, rst_in (async, active-high), rdy_in (global enable / stall)
//   rob_to_commit_en_in, instr_id_in, rd_in, rob_pos_in, res_in,
//   jump_en_in, jump_a_in, pc_in, bp_in       : retiring ROB entry
//   rf_wr_en_out, rf_rd_out, rf_res_out,
//   rf_rob_pos_out                            : register-file writeback
//   bp_upd_en_out, bp_upd_pc_out,
//   bp_upd_taken_out                          : predictor training
//   redirect_en_out, redirect_pc_out          : fetch redirect
//   clear_branch_out                          : global flush
//   commit_cnt_out, mispredict_cnt_out        : performance counters
module commit_unit #(
  parameter int ADDR_W       = 32,
  parameter int WORD_W       = 32,
  parameter int REG_IDX_W    = 5,
  parameter int ROB_IDX_W    = 4,
  parameter int INSTR_ID_W   = 6,
  parameter int BR_ID_LO     = 1,
  parameter int BR_ID_HI     = 6,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  rob_to_commit_en_in,
  input  logic [INSTR_ID_W-1:0] instr_id_in,
  input  logic [REG_IDX_W-1:0]  rd_in,
  input  logic [ROB_IDX_W-1:0]  rob_pos_in,
  input  logic [WORD_W-1:0]     res_in,
  input  logic                  jump_en_in,
  input  logic [ADDR_W-1:0]     jump_a_in,
  input  logic [ADDR_W-1:0]     pc_in,
  input  logic                  bp_in,
  output logic                  rf_wr_en_out,
  output logic [REG_IDX_W-1:0]  rf_rd_out,
  output logic [WORD_W-1:0]     rf_res_out,
  output logic [ROB_IDX_W-1:0]  rf_rob_pos_out,
  output logic                  bp_upd_en_out,
  output logic [ADDR_W-1:0]     bp_upd_pc_out,
  output logic                  bp_upd_taken_out,
  output logic                  redirect_en_out,
  output logic [ADDR_W-1:0]     redirect_pc_out,
  output logic                  clear_branch_out,
  output logic [31:0]           commit_cnt_out,
  output logic [31:0]           mispredict_cnt_out
);

  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;

  localparam logic [INSTR_ID_W-1:0] BR_LO     = INSTR_ID_W'(BR_ID_LO);
  localparam logic [INSTR_ID_W-1:0] BR_HI     = INSTR_ID_W'(BR_ID_HI);
  localparam logic [CNT_W-1:0]      FLUSH_LD  = CNT_W'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);

  // Conditional branches occupy a contiguous block of instruction ids.
  function automatic logic is_cond_branch(input logic [INSTR_ID_W-1:0] id);
    return (id >= BR_LO) && (id <= BR_HI);
  endfunction

  // Correct-path address: the resolved target when the instruction
  // redirected, otherwise the fall-through (wraps modulo 2^ADDR_W).
  function automatic logic [ADDR_W-1:0] correct_pc(
    input logic              jump_en,
    input logic [ADDR_W-1:0] jump_a,
    input logic [ADDR_W-1:0] pc
  );
    return jump_en ? jump_a : pc + ADDR_W'(4);
  endfunction

  logic [0:0]           state_q;
  logic [CNT_W-1:0]     flush_cnt_q;

  logic                 wb_vld_p1;
  logic [REG_IDX_W-1:0] wb_rd_p1;
  logic [WORD_W-1:0]    wb_res_p1;
  logic [ROB_IDX_W-1:0] wb_pos_p1;

  logic                 bp_vld_p1;
  logic [ADDR_W-1:0]    bp_pc_p1;
  logic                 bp_taken_p1;

  logic                 redir_vld_p1;
  logic [ADDR_W-1:0]    redir_pc_p1;
  logic                 clear_p1;

  logic [31:0]          commit_cnt_q;
  logic [31:0]          mispredict_cnt_q;

  logic                 accept;
  logic                 mispredict;

  // JALR reports bp=0 / jump_en=1, so it lands here without special casing.
  assign accept     = (state_q == RUN) && rob_to_commit_en_in;
  assign mispredict = accept && (jump_en_in != bp_in);

  // ---- stage p0 -> p1: sample retiring entry, register all outputs ----
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q          <= RUN;
      flush_cnt_q      <= '0;
      wb_vld_p1        <= 1'b0;
      wb_rd_p1         <= '0;
      wb_res_p1        <= '0;
      wb_pos_p1        <= '0;
      bp_vld_p1        <= 1'b0;
      bp_pc_p1         <= '0;
      bp_taken_p1      <= 1'b0;
      redir_vld_p1     <= 1'b0;
      redir_pc_p1      <= '0;
      clear_p1         <= 1'b0;
      commit_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else if (rdy_in) begin
      wb_vld_p1    <= 1'b0;
      bp_vld_p1    <= 1'b0;
      redir_vld_p1 <= 1'b0;

      if (accept) begin
        commit_cnt_q <= commit_cnt_q + 32'd1;

        if (rd_in != '0) begin
          wb_vld_p1 <= 1'b1;
          wb_rd_p1  <= rd_in;
          wb_res_p1 <= res_in;
          wb_pos_p1 <= rob_pos_in;
        end

        if (is_cond_branch(instr_id_in)) begin
          bp_vld_p1   <= 1'b1;
          bp_pc_p1    <= pc_in;
          bp_taken_p1 <= jump_en_in;
        end
      end

      if (mispredict) begin
        redir_vld_p1     <= 1'b1;
        redir_pc_p1      <= correct_pc(jump_en_in, jump_a_in, pc_in);
        clear_p1         <= 1'b1;
        flush_cnt_q      <= FLUSH_LD;
        state_q          <= FLUSH;
        mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
      end

      // Wrong-path entries presented during FLUSH are simply not accepted.
      // The counter value at the edge decides whether clear survives it.
      if (state_q == FLUSH) begin
        if (flush_cnt_q > CNT_ONE) begin
          flush_cnt_q <= flush_cnt_q - CNT_ONE;
        end else begin
          flush_cnt_q <= '0;
          clear_p1    <= 1'b0;
          state_q     <= RUN;
        end
      end
    end
  end

  assign rf_wr_en_out       = wb_vld_p1;
  assign rf_rd_out          = wb_rd_p1;
  assign rf_res_out         = wb_res_p1;
  assign rf_rob_pos_out     = wb_pos_p1;
  assign bp_upd_en_out      = bp_vld_p1;
  assign bp_upd_pc_out      = bp_pc_p1;
  assign bp_upd_taken_out   = bp_taken_p1;
  assign redirect_en_out    = redir_vld_p1;
  assign redirect_pc_out    = redir_pc_p1;
  assign clear_branch_out   = clear_p1;
  assign commit_cnt_out     = commit_cnt_q;
  assign mispredict_cnt_out = mispredict_cnt_q;

endmodule

// File: tb/tb_commit_unit.sv
// Directed bench for commit_unit with default parameters.
module tb_commit_unit;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        rob_to_commit_en_in;
  logic [5:0]  instr_id_in;
  logic [4:0]  rd_in;
  logic [3:0]  rob_pos_in;
  logic [31:0] res_in;
  logic        jump_en_in;
  logic [31:0] jump_a_in;
  logic [31:0] pc_in;
  logic        bp_in;
  logic        rf_wr_en_out;
  logic [4:0]  rf_rd_out;
  logic [31:0] rf_res_out;
  logic [3:0]  rf_rob_pos_out;
  logic        bp_upd_en_out;
  logic [31:0] bp_upd_pc_out;
  logic        bp_upd_taken_out;
  logic        redirect_en_out;
  logic [31:0] redirect_pc_out;
  logic        clear_branch_out;
  logic [31:0] commit_cnt_out;
  logic [31:0] mispredict_cnt_out;

  int n_tests = 0;
  int n_fail  = 0;

  commit_unit dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .rdy_in              (rdy_in),
    .rob_to_commit_en_in (rob_to_commit_en_in),
    .instr_id_in         (instr_id_in),
    .rd_in               (rd_in),
    .rob_pos_in          (rob_pos_in),
    .res_in              (res_in),
    .jump_en_in          (jump_en_in),
    .jump_a_in           (jump_a_in),
    .pc_in               (pc_in),
    .bp_in               (bp_in),
    .rf_wr_en_out        (rf_wr_en_out),
    .rf_rd_out           (rf_rd_out),
    .rf_res_out          (rf_res_out),
    .rf_rob_pos_out      (rf_rob_pos_out),
    .bp_upd_en_out       (bp_upd_en_out),
    .bp_upd_pc_out       (bp_upd_pc_out),
    .bp_upd_taken_out    (bp_upd_taken_out),
    .redirect_en_out     (redirect_en_out),
    .redirect_pc_out     (redirect_pc_out),
    .clear_branch_out    (clear_branch_out),
    .commit_cnt_out      (commit_cnt_out),
    .mispredict_cnt_out  (mispredict_cnt_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk_eq(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One active edge, then settle so outputs are sampled away from it.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic en, input logic [5:0] id,
                       input logic [4:0] rd, input logic [3:0] pos,
                       input logic [31:0] res, input logic jmp,
                       input logic [31:0] ja, input logic [31:0] pc,
                       input logic bp);
    rob_to_commit_en_in = en;
    instr_id_in         = id;
    rd_in               = rd;
    rob_pos_in          = pos;
    res_in              = res;
    jump_en_in          = jmp;
    jump_a_in           = ja;
    pc_in               = pc;
    bp_in               = bp;
  endtask

  task automatic idle();
    drive(1'b0, 6'd0, 5'd0, 4'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_in = 1'b1;
    rdy_in = 1'b1;
    idle();
    step();
    step();
    chk_eq("rst_wr_en", rf_wr_en_out, 0);
    chk_eq("rst_clear", clear_branch_out, 0);
    chk_eq("rst_redir", redirect_en_out, 0);
    chk_eq("rst_cnt", commit_cnt_out, 0);
    chk_eq("rst_mis", mispredict_cnt_out, 0);
    rst_in = 1'b0;

    // Plain commit, id outside the branch range
    drive(1'b1, 6'd20, 5'd5, 4'd3, 32'hDEADBEEF, 1'b0, 32'd0, 32'h40, 1'b0);
    step();
    chk_eq("plain_wr_en", rf_wr_en_out, 1);
    chk_eq("plain_rd", rf_rd_out, 5);
    chk_eq("plain_res", rf_res_out, 32'hDEADBEEF);
    chk_eq("plain_pos", rf_rob_pos_out, 3);
    chk_eq("plain_cnt", commit_cnt_out, 1);
    chk_eq("plain_bpupd", bp_upd_en_out, 0);
    chk_eq("plain_redir", redirect_en_out, 0);

    // rd = x0: counted, never written
    drive(1'b1, 6'd20, 5'd0, 4'd4, 32'h1234, 1'b0, 32'd0, 32'h44, 1'b0);
    step();
    chk_eq("rd0_wr_en", rf_wr_en_out, 0);
    chk_eq("rd0_cnt", commit_cnt_out, 2);

    // Back-to-back commits, last one a correctly predicted branch
    drive(1'b1, 6'd30, 5'd7, 4'd5, 32'd1, 1'b0, 32'd0, 32'h48, 1'b0);
    step();
    chk_eq("b2b0_rd", rf_rd_out, 7);
    chk_eq("b2b0_cnt", commit_cnt_out, 3);
    drive(1'b1, 6'd30, 5'd8, 4'd6, 32'd2, 1'b0, 32'd0, 32'h4C, 1'b0);
    step();
    chk_eq("b2b1_wr_en", rf_wr_en_out, 1);
    chk_eq("b2b1_res", rf_res_out, 2);
    chk_eq("b2b1_cnt", commit_cnt_out, 4);
    drive(1'b1, 6'd3, 5'd0, 4'd7, 32'd0, 1'b0, 32'd0, 32'h50, 1'b0);
    step();
    chk_eq("brok_bpupd", bp_upd_en_out, 1);
    chk_eq("brok_bppc", bp_upd_pc_out, 32'h50);
    chk_eq("brok_taken", bp_upd_taken_out, 0);
    chk_eq("brok_redir", redirect_en_out, 0);
    chk_eq("brok_clear", clear_branch_out, 0);
    chk_eq("brok_cnt", commit_cnt_out, 5);

    // Branch predicted taken, actually not taken
    drive(1'b1, 6'd2, 5'd0, 4'd8, 32'd0, 1'b0, 32'h999, 32'h100, 1'b1);
    step();
    chk_eq("mis_redir", redirect_en_out, 1);
    chk_eq("mis_redir_pc", redirect_pc_out, 32'h104);
    chk_eq("mis_bpupd", bp_upd_en_out, 1);
    chk_eq("mis_taken", bp_upd_taken_out, 0);
    chk_eq("mis_clear", clear_branch_out, 1);
    chk_eq("mis_mcnt", mispredict_cnt_out, 1);
    chk_eq("mis_cnt", commit_cnt_out, 6);
    chk_eq("mis_wr_en", rf_wr_en_out, 0);

    // Wrong-path entries presented every cycle during the flush
    drive(1'b1, 6'd3, 5'd9, 4'd9, 32'hBAD, 1'b1, 32'h700, 32'h104, 1'b0);
    step();
    chk_eq("wp1_clear", clear_branch_out, 1);
    chk_eq("wp1_redir", redirect_en_out, 0);
    chk_eq("wp1_wr_en", rf_wr_en_out, 0);
    chk_eq("wp1_bpupd", bp_upd_en_out, 0);
    chk_eq("wp1_cnt", commit_cnt_out, 6);
    step();
    chk_eq("wp2_clear", clear_branch_out, 0);
    chk_eq("wp2_wr_en", rf_wr_en_out, 0);
    chk_eq("wp2_cnt", commit_cnt_out, 6);
    chk_eq("wp2_mcnt", mispredict_cnt_out, 1);
    drive(1'b1, 6'd20, 5'd10, 4'd10, 32'h33, 1'b0, 32'd0, 32'h104, 1'b0);
    step();
    chk_eq("post_wr_en", rf_wr_en_out, 1);
    chk_eq("post_rd", rf_rd_out, 10);
    chk_eq("post_cnt", commit_cnt_out, 7);

    // JALR at 0x200 writing x1, then a 3-cycle stall mid-flush
    drive(1'b1, 6'd40, 5'd1, 4'd11, 32'h204, 1'b1, 32'h80, 32'h200, 1'b0);
    step();
    chk_eq("jalr_wr_en", rf_wr_en_out, 1);
    chk_eq("jalr_rd", rf_rd_out, 1);
    chk_eq("jalr_res", rf_res_out, 32'h204);
    chk_eq("jalr_redir_pc", redirect_pc_out, 32'h80);
    chk_eq("jalr_bpupd", bp_upd_en_out, 0);
    chk_eq("jalr_mcnt", mispredict_cnt_out, 2);
    chk_eq("jalr_cnt", commit_cnt_out, 8);
    idle();
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_eq("stall_clear", clear_branch_out, 1);
      chk_eq("stall_redir", redirect_en_out, 1);
      chk_eq("stall_wr_en", rf_wr_en_out, 1);
    end
    rdy_in = 1'b1;
    step();
    chk_eq("unst1_clear", clear_branch_out, 1);
    chk_eq("unst1_redir", redirect_en_out, 0);
    step();
    chk_eq("unst2_clear", clear_branch_out, 0);

    // Lowest branch id, fall-through wraps past the top of the address space
    drive(1'b1, 6'd1, 5'd0, 4'd12, 32'd0, 1'b0, 32'd0, 32'hFFFFFFFC, 1'b1);
    step();
    chk_eq("wrap_bpupd", bp_upd_en_out, 1);
    chk_eq("wrap_redir_pc", redirect_pc_out, 32'h0);
    chk_eq("wrap_mcnt", mispredict_cnt_out, 3);
    idle();
    step();
    step();
    chk_eq("wrap_end_clear", clear_branch_out, 0);

    // Ids just outside the branch range
    drive(1'b1, 6'd7, 5'd0, 4'd13, 32'd0, 1'b0, 32'd0, 32'h60, 1'b0);
    step();
    chk_eq("id7_bpupd", bp_upd_en_out, 0);
    chk_eq("id7_cnt", commit_cnt_out, 10);
    drive(1'b1, 6'd0, 5'd0, 4'd14, 32'd0, 1'b0, 32'd0, 32'h64, 1'b0);
    step();
    chk_eq("id0_bpupd", bp_upd_en_out, 0);
    chk_eq("id0_cnt", commit_cnt_out, 11);

    // Highest branch id, predicted not taken but taken; reset mid-flush
    drive(1'b1, 6'd6, 5'd0, 4'd15, 32'd0, 1'b1, 32'h300, 32'h68, 1'b0);
    step();
    chk_eq("id6_bpupd", bp_upd_en_out, 1);
    chk_eq("id6_taken", bp_upd_taken_out, 1);
    chk_eq("id6_redir_pc", redirect_pc_out, 32'h300);
    chk_eq("id6_clear", clear_branch_out, 1);
    chk_eq("id6_mcnt", mispredict_cnt_out, 4);
    chk_eq("id6_cnt", commit_cnt_out, 12);
    idle();
    #2;
    rst_in = 1'b1;
    #1;
    chk_eq("arst_clear", clear_branch_out, 0);
    chk_eq("arst_redir", redirect_en_out, 0);
    chk_eq("arst_bpupd", bp_upd_en_out, 0);
    chk_eq("arst_cnt", commit_cnt_out, 0);
    chk_eq("arst_mcnt", mispredict_cnt_out, 0);
    step();
    rst_in = 1'b0;
    drive(1'b1, 6'd20, 5'd4, 4'd1, 32'h44, 1'b0, 32'd0, 32'h0, 1'b0);
    step();
    chk_eq("after_rst_wr_en", rf_wr_en_out, 1);
    chk_eq("after_rst_rd", rf_rd_out, 4);
    chk_eq("after_rst_cnt", commit_cnt_out, 1);
    idle();
    step();
    chk_eq("idle_wr_en", rf_wr_en_out, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
